// File: rtl/wb_arbiter_pkg.sv
// Shared encodings and bus widths for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam logic M_FETCH = 1'b0;
    localparam logic M_DATA  = 1'b1;

    // Grant states are encoded so that they read directly as the one-hot grant.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    function automatic logic [1:0] grant_of(arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GNT0:    g = 2'b01;
            GNT1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    function automatic arb_state_e state_for(logic m);
        return (m == M_DATA) ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Watchdog for one granted transfer: counts cycles without ack/err and fires
// a single-cycle pulse when the allowed wait runs out.
module wb_arb_watchdog
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active,
    input  logic done,
    output logic fire
);

    localparam logic          ENABLE    = (TIMEOUT_CYCLES > 0);
    localparam int            FIRE_AT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] FIRE_AT   = FIRE_AT_I[TW-1:0];
    localparam logic [TW-1:0] COUNT_MAX = '1;

    logic [TW-1:0] count;

    // Held at zero while idle, so every grant starts counting from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (!active) begin
            count <= '0;
        end else if (!done && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign fire = ENABLE & active & ~done & (count == FIRE_AT);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave classic Wishbone arbiter: instruction fetch (m0) and
// load/store (m1) share the external bus, one transfer per grant.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int RR_MODE        = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,

    output logic [1:0]       grant_o
);

    arb_state_e state, state_next;
    logic       last_grant, last_grant_next;
    logic       winner;

    logic             cyc, stb, we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] wdat;

    logic granted;
    logic done;
    logic wd_fire;

    assign granted = (state == GNT0) || (state == GNT1);
    assign done    = s_ack_i | s_err_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_grant <= M_FETCH;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // A grant always returns to IDLE, which gives the mandatory one-cycle
    // bubble before the next arbitration.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        winner          = M_DATA;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    winner = (RR_MODE != 0) ? ~last_grant : M_DATA;
                end else begin
                    winner = m1_cyc_i ? M_DATA : M_FETCH;
                end
                if (m0_cyc_i || m1_cyc_i) begin
                    state_next      = state_for(winner);
                    last_grant_next = winner;
                end
            end
            GNT0, GNT1: begin
                if (!cyc || done || wd_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        sel  = '0;
        adr  = '0;
        wdat = '0;
        case (state)
            GNT0: begin
                cyc  = m0_cyc_i;
                stb  = m0_stb_i;
                we   = m0_we_i;
                sel  = m0_sel_i;
                adr  = m0_adr_i;
                wdat = m0_dat_i;
            end
            GNT1: begin
                cyc  = m1_cyc_i;
                stb  = m1_stb_i;
                we   = m1_we_i;
                sel  = m1_sel_i;
                adr  = m1_adr_i;
                wdat = m1_dat_i;
            end
            default: ;
        endcase
    end

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .active (granted),
        .done   (done),
        .fire   (wd_fire)
    );

    // The timed-out cycle is withdrawn from the slave while the error is
    // reported to the master.
    assign s_cyc_o = cyc & ~wd_fire;
    assign s_stb_o = stb & ~wd_fire;
    assign s_we_o  = we;
    assign s_sel_o = sel;
    assign s_adr_o = adr;
    assign s_dat_o = wdat;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = (state == GNT0) & m0_cyc_i & s_ack_i;
    assign m0_err_o = (state == GNT0) & m0_cyc_i & (s_err_i | wd_fire);
    assign m1_ack_o = (state == GNT1) & m1_cyc_i & s_ack_i;
    assign m1_err_o = (state == GNT1) & m1_cyc_i & (s_err_i | wd_fire);

    assign grant_o = grant_of(state);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: three configurations driven by shared stimulus and
// checked every cycle against a per-instance behavioural model.
module tb_wb_arbiter;

    localparam int N = 3;
    localparam logic [N-1:0]   RR_BITS = 3'b110;
    localparam logic [N*8-1:0] TO_BITS = {8'd7, 8'd0, 8'd4};

    typedef logic [140:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [31:0] s_dat_in;
    logic        s_ack, s_err;

    logic        o_s_cyc [N];
    logic        o_s_stb [N];
    logic        o_s_we  [N];
    logic [3:0]  o_s_sel [N];
    logic [31:0] o_s_adr [N];
    logic [31:0] o_s_dat [N];
    logic [31:0] o_m0_dat [N];
    logic [31:0] o_m1_dat [N];
    logic        o_m0_ack [N];
    logic        o_m0_err [N];
    logic        o_m1_ack [N];
    logic        o_m1_err [N];
    logic [1:0]  o_grant [N];

    int vectors;
    int miscompares;

    // Model state: current owner (-1 = nobody), last owner, cycles waited.
    int own    [N];
    int last   [N];
    int waited [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_arbiter #(
            .RR_MODE        (int'(RR_BITS[g])),
            .TIMEOUT_CYCLES (int'(TO_BITS[g*8 +: 8])),
            .TW             (8)
        ) dut (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .m0_cyc_i (m0_cyc),
            .m0_stb_i (m0_stb),
            .m0_we_i  (m0_we),
            .m0_sel_i (m0_sel),
            .m0_adr_i (m0_adr),
            .m0_dat_i (m0_dat),
            .m0_dat_o (o_m0_dat[g]),
            .m0_ack_o (o_m0_ack[g]),
            .m0_err_o (o_m0_err[g]),
            .m1_cyc_i (m1_cyc),
            .m1_stb_i (m1_stb),
            .m1_we_i  (m1_we),
            .m1_sel_i (m1_sel),
            .m1_adr_i (m1_adr),
            .m1_dat_i (m1_dat),
            .m1_dat_o (o_m1_dat[g]),
            .m1_ack_o (o_m1_ack[g]),
            .m1_err_o (o_m1_err[g]),
            .s_cyc_o  (o_s_cyc[g]),
            .s_stb_o  (o_s_stb[g]),
            .s_we_o   (o_s_we[g]),
            .s_sel_o  (o_s_sel[g]),
            .s_adr_o  (o_s_adr[g]),
            .s_dat_o  (o_s_dat[g]),
            .s_dat_i  (s_dat_in),
            .s_ack_i  (s_ack),
            .s_err_i  (s_err),
            .grant_o  (o_grant[g])
        );
    end

    function automatic vec_t pack_obs(int g);
        return {o_grant[g], o_s_cyc[g], o_s_stb[g], o_s_we[g], o_s_sel[g],
                o_s_adr[g], o_s_dat[g], o_m0_ack[g], o_m0_err[g],
                o_m1_ack[g], o_m1_err[g], o_m0_dat[g], o_m1_dat[g]};
    endfunction

    function automatic bit fire_now(int g);
        int to;
        to = int'(TO_BITS[g*8 +: 8]);
        return (to > 0) && (waited[g] == to - 1) && !(s_ack || s_err);
    endfunction

    function automatic vec_t model_exp(int g);
        logic [1:0]  gr;
        logic        c, scyc, sstb, swe, a0, e0, a1, e1, fire;
        logic [3:0]  ssel;
        logic [31:0] sadr, sdat;
        gr = 2'b00; scyc = 1'b0; sstb = 1'b0; swe = 1'b0; ssel = 4'h0;
        sadr = 32'h0; sdat = 32'h0; a0 = 1'b0; e0 = 1'b0; a1 = 1'b0; e1 = 1'b0;
        if (rst_n && own[g] >= 0) begin
            fire = fire_now(g);
            c    = (own[g] == 1) ? m1_cyc : m0_cyc;
            gr   = (own[g] == 1) ? 2'b10 : 2'b01;
            scyc = c && !fire;
            sstb = ((own[g] == 1) ? m1_stb : m0_stb) && !fire;
            swe  = (own[g] == 1) ? m1_we  : m0_we;
            ssel = (own[g] == 1) ? m1_sel : m0_sel;
            sadr = (own[g] == 1) ? m1_adr : m0_adr;
            sdat = (own[g] == 1) ? m1_dat : m0_dat;
            if (own[g] == 1) begin
                a1 = s_ack && c;
                e1 = (s_err || fire) && c;
            end else begin
                a0 = s_ack && c;
                e0 = (s_err || fire) && c;
            end
        end
        return {gr, scyc, sstb, swe, ssel, sadr, sdat, a0, e0, a1, e1, s_dat_in, s_dat_in};
    endfunction

    function automatic void advance(int g);
        logic c;
        if (!rst_n) begin
            own[g] = -1; last[g] = 0; waited[g] = 0;
        end else if (own[g] < 0) begin
            if (m0_cyc && m1_cyc)  own[g] = RR_BITS[g] ? 1 - last[g] : 1;
            else if (m1_cyc)       own[g] = 1;
            else if (m0_cyc)       own[g] = 0;
            if (own[g] >= 0) begin
                last[g] = own[g];
                waited[g] = 0;
            end
        end else begin
            c = (own[g] == 1) ? m1_cyc : m0_cyc;
            if (!c || s_ack || s_err || fire_now(g)) own[g] = -1;
            else waited[g]++;
        end
    endfunction

    // Compare all instances against the model, then step the model over the
    // coming rising edge using the inputs currently applied.
    task automatic check(input string tag);
        vec_t o, e;
        #1;
        for (int g = 0; g < N; g++) begin
            o = pack_obs(g);
            e = model_exp(g);
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s dut%0d: observed %h expected %h", tag, g, o, e);
            end
        end
        for (int g = 0; g < N; g++) advance(g);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = 32'h0; m0_dat = 32'h0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = 32'h0; m1_dat = 32'h0;
        s_dat_in = 32'h0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        check("rst");
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_rel");
    endtask

    initial begin
        int seen[$];
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        clear_inputs();
        for (int g = 0; g < N; g++) begin
            own[g] = -1; last[g] = 0; waited[g] = 0;
        end

        // Reset state
        @(negedge clk); check("reset");
        for (int g = 0; g < N; g++) expect_val("reset_grant", 32'(o_grant[g]), 32'd0);
        @(negedge clk); rst_n = 1'b1; check("release");

        // m0 read alone
        @(negedge clk); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100; check("m0_req");
        expect_val("m0_req_scyc", 32'(o_s_cyc[0]), 32'd0);
        @(negedge clk); check("m0_gnt");
        expect_val("m0_gnt_grant", 32'(o_grant[0]), 32'd1);
        expect_val("m0_gnt_scyc", 32'(o_s_cyc[0]), 32'd1);
        expect_val("m0_gnt_adr", o_s_adr[0], 32'h0000_0100);
        @(negedge clk); check("m0_wait");
        @(negedge clk); s_ack = 1'b1; s_dat_in = 32'hDEAD_BEEF; check("m0_ack");
        expect_val("m0_ack", 32'(o_m0_ack[0]), 32'd1);
        expect_val("m0_rdata", o_m0_dat[0], 32'hDEAD_BEEF);
        expect_val("m0_ack_m1", 32'(o_m1_ack[0]), 32'd0);
        @(negedge clk); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; check("m0_done");
        expect_val("m0_done_grant", 32'(o_grant[0]), 32'd0);

        // Simultaneous requests from reset, fixed priority
        do_reset();
        @(negedge clk);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_2000;
        m1_dat = 32'h1234_5678; m1_sel = 4'hF;
        check("tie_req");
        @(negedge clk); check("tie_g1");
        expect_val("tie_g1_grant", 32'(o_grant[0]), 32'd2);
        expect_val("tie_g1_wdat", o_s_dat[0], 32'h1234_5678);
        expect_val("tie_g1_adr", o_s_adr[0], 32'h0000_2000);
        expect_val("tie_g1_rr_grant", 32'(o_grant[1]), 32'd2);
        @(negedge clk); s_ack = 1'b1; check("tie_ack1");
        expect_val("tie_ack1_m1", 32'(o_m1_ack[0]), 32'd1);
        expect_val("tie_ack1_m0", 32'(o_m0_ack[0]), 32'd0);
        @(negedge clk); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; check("tie_bubble");
        expect_val("tie_bubble_grant", 32'(o_grant[0]), 32'd0);
        @(negedge clk); check("tie_g0");
        expect_val("tie_g0_grant", 32'(o_grant[0]), 32'd1);
        @(negedge clk); s_ack = 1'b1; check("tie_ack0");
        expect_val("tie_ack0_m0", 32'(o_m0_ack[0]), 32'd1);
        @(negedge clk); clear_inputs(); check("tie_end");

        // Round-robin with both masters requesting continuously
        do_reset();
        @(negedge clk); m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
        check("rr_start");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); check("rr_run");
            if (o_grant[1] != 2'b00) seen.push_back(int'(o_grant[1]));
        end
        expect_val("rr_count", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            expect_val("rr_order", (i < seen.size()) ? 32'(seen[i]) : 32'd0, (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        @(negedge clk); clear_inputs(); check("rr_end");

        // Watchdog: no ack, then ack on the last permitted cycle
        do_reset();
        @(negedge clk); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0300; check("wd_req");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("wd_wait");
        end
        @(negedge clk); check("wd_fire");
        expect_val("wd_fire_err", 32'(o_m0_err[0]), 32'd1);
        expect_val("wd_fire_scyc", 32'(o_s_cyc[0]), 32'd0);
        expect_val("wd_fire_sstb", 32'(o_s_stb[0]), 32'd0);
        expect_val("wd_off_err", 32'(o_m0_err[1]), 32'd0);
        @(negedge clk); check("wd_idle");
        expect_val("wd_idle_grant", 32'(o_grant[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("wd_wait2");
        end
        @(negedge clk); s_ack = 1'b1; check("wd_ack");
        expect_val("wd_ack_ack", 32'(o_m0_ack[0]), 32'd1);
        expect_val("wd_ack_err", 32'(o_m0_err[0]), 32'd0);
        expect_val("wd_ack_scyc", 32'(o_s_cyc[0]), 32'd1);
        @(negedge clk); clear_inputs(); check("wd_end");

        // Abort: m1 withdraws while the slave acks
        do_reset();
        @(negedge clk); m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0400; check("ab_req");
        @(negedge clk); check("ab_gnt");
        expect_val("ab_gnt_grant", 32'(o_grant[0]), 32'd2);
        @(negedge clk); m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1; check("ab_drop");
        expect_val("ab_drop_scyc", 32'(o_s_cyc[0]), 32'd0);
        expect_val("ab_drop_ack", 32'(o_m1_ack[0]), 32'd0);
        @(negedge clk); s_ack = 1'b0; check("ab_idle");
        expect_val("ab_idle_grant", 32'(o_grant[0]), 32'd0);

        // Asynchronous reset in the middle of a grant
        do_reset();
        @(negedge clk); m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; check("ar_req");
        @(negedge clk); check("ar_gnt");
        @(posedge clk); #2;
        rst_n = 1'b0; s_ack = 1'b1;
        check("ar_async");
        for (int g = 0; g < N; g++) begin
            expect_val("ar_scyc", 32'(o_s_cyc[g]), 32'd0);
            expect_val("ar_grant", 32'(o_grant[g]), 32'd0);
            expect_val("ar_acks", 32'({o_m0_ack[g], o_m1_ack[g]}), 32'd0);
        end
        @(negedge clk); s_ack = 1'b0; check("ar_hold");
        @(negedge clk); rst_n = 1'b1; check("ar_rel");
        @(negedge clk); check("ar_first");
        expect_val("ar_first_rr", 32'(o_grant[1]), 32'd2);
        expect_val("ar_first_rr7", 32'(o_grant[2]), 32'd2);

        // Randomized traffic
        @(negedge clk); clear_inputs(); check("rand_start");
        for (int blk = 0; blk < 12; blk++) begin
            int den;
            den = int'($urandom_range(2, 6));
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
                if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
                m0_stb = ($urandom_range(0, 4) != 0);
                m1_stb = ($urandom_range(0, 4) != 0);
                m0_we  = 1'($urandom);
                m1_we  = 1'($urandom);
                m0_sel = 4'($urandom);
                m1_sel = 4'($urandom);
                m0_adr = $urandom;
                m1_adr = $urandom;
                m0_dat = $urandom;
                m1_dat = $urandom;
                s_dat_in = $urandom;
                s_ack = ($urandom_range(0, den - 1) == 0);
                s_err = ($urandom_range(0, 15) == 0);
                rst_n = ($urandom_range(0, 199) != 0);
                check("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
